// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, 11 device-clocked bits, ACK check.
// Pins are driven open-drain through the *_oe outputs (1 = pull low).
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_error
);
    // state     | meaning
    // IDLE      | lines released, waiting for tx_start
    // INHIBIT   | ps2_clk held low for INHIBIT_CYCLES
    // RTS       | clk and data both low (start bit), one cycle
    // SEND      | clock released, data follows shreg[0], shift on each device falling edge
    // ACK       | lines released, device ACK sampled on next falling edge
    // WAIT_IDLE | wait for both lines high
    // DONE      | tx_done pulse
    // ERR       | tx_error pulse (NACK or timeout)
    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [INH_W-1:0] INH_LOAD = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_RTS,
        S_SEND,
        S_ACK,
        S_WAIT_IDLE,
        S_DONE,
        S_ERR
    } state_t;

    state_t           r_state;
    logic             r_clk_meta;
    logic             r_clk_sync;
    logic             r_clk_prev;
    logic             r_dat_meta;
    logic             r_dat_sync;
    logic [10:0]      r_shreg;
    logic [3:0]       r_bitcnt;
    logic [INH_W-1:0] r_inh_cnt;
    logic [TMO_W-1:0] r_tmo_cnt;

    logic w_fe;
    logic w_tmo_hit;
    logic w_parity;

    assign w_fe      = r_clk_prev & ~r_clk_sync;
    assign w_tmo_hit = (r_tmo_cnt == '0);
    assign w_parity  = ~^tx_data;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state    <= S_IDLE;
            r_clk_meta <= 1'b1;
            r_clk_sync <= 1'b1;
            r_clk_prev <= 1'b1;
            r_dat_meta <= 1'b1;
            r_dat_sync <= 1'b1;
            r_shreg    <= '0;
            r_bitcnt   <= '0;
            r_inh_cnt  <= '0;
            r_tmo_cnt  <= '0;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            busy       <= 1'b0;
            tx_done    <= 1'b0;
            tx_error   <= 1'b0;
        end else begin
            r_clk_meta <= ps2_clk_in;
            r_clk_sync <= r_clk_meta;
            r_clk_prev <= r_clk_sync;
            r_dat_meta <= ps2_dat_in;
            r_dat_sync <= r_dat_meta;
            tx_done    <= 1'b0;
            tx_error   <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    ps2_clk_oe <= 1'b0;
                    ps2_dat_oe <= 1'b0;
                    busy       <= 1'b0;
                    if (tx_start) begin
                        // start bit sits in bit 0 so it is already on the line when the clock is released
                        r_shreg    <= {1'b1, w_parity, tx_data, 1'b0};
                        r_inh_cnt  <= INH_LOAD;
                        busy       <= 1'b1;
                        ps2_clk_oe <= 1'b1;
                        r_state    <= S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    if (r_inh_cnt == '0) begin
                        ps2_dat_oe <= 1'b1;
                        r_state    <= S_RTS;
                    end else begin
                        r_inh_cnt <= r_inh_cnt - 1'b1;
                    end
                end
                S_RTS: begin
                    ps2_clk_oe <= 1'b0;
                    r_bitcnt   <= '0;
                    r_tmo_cnt  <= TMO_LOAD;
                    r_state    <= S_SEND;
                end
                S_SEND, S_ACK, S_WAIT_IDLE: begin
                    // timeout wins over a falling edge arriving in the same cycle
                    if (w_tmo_hit) begin
                        ps2_clk_oe <= 1'b0;
                        ps2_dat_oe <= 1'b0;
                        tx_error   <= 1'b1;
                        r_state    <= S_ERR;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt - 1'b1;
                        if (r_state == S_SEND) begin
                            if (w_fe) begin
                                r_shreg  <= {1'b1, r_shreg[10:1]};
                                r_bitcnt <= r_bitcnt + 4'd1;
                                if (r_bitcnt == 4'd9) begin
                                    ps2_dat_oe <= 1'b0;
                                    r_state    <= S_ACK;
                                end else begin
                                    ps2_dat_oe <= ~r_shreg[1];
                                end
                            end
                        end else if (r_state == S_ACK) begin
                            ps2_dat_oe <= 1'b0;
                            if (w_fe) begin
                                if (r_dat_sync) begin
                                    tx_error <= 1'b1;
                                    r_state  <= S_ERR;
                                end else begin
                                    r_state <= S_WAIT_IDLE;
                                end
                            end
                        end else if (r_clk_sync && r_dat_sync) begin
                            tx_done <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                S_ERR: begin
                    ps2_clk_oe <= 1'b0;
                    ps2_dat_oe <= 1'b0;
                    busy       <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
